// File: rtl/lfsr_gen.sv
// Fibonacci-style XNOR LFSR with step counter, wrap detection against the last seed, and lock-up flag.
// Optional all-ones lock-up recovery is enabled by defining LFSR_GEN_LOCKUP_RECOVER_EN.
module lfsr_gen #(
  parameter int          WIDTH = 8,
  parameter logic [31:0] TAPS  = 32'h0000_00B8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             lockup,
  output logic             recovered
);

  localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] seed_ref;
  logic [WIDTH-1:0] q_step;
  logic             fb;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ref_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // XNOR feedback: all-zeros is a legal state, all-ones is the stuck state
  assign fb      = ~^(q & TAP_MASK);
  assign q_step  = {q[WIDTH-2:0], fb};
  assign bit_out = q[WIDTH-1];
  assign lockup  = &q;

`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
  logic rec_nxt;
`endif

  always_comb begin
    q_nxt     = q;
    ref_nxt   = seed_ref;
    count_nxt = count;
    wrap_nxt  = 1'b0;
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
    rec_nxt   = 1'b0;
`endif
    if (load) begin
      q_nxt     = seed;
      ref_nxt   = seed;
      count_nxt = '0;
    end else if (en) begin
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
      if (lockup) begin
        q_nxt     = '0;
        ref_nxt   = '0;
        count_nxt = '0;
        rec_nxt   = 1'b1;
      end else begin
        q_nxt     = q_step;
        count_nxt = count + ONE;
        wrap_nxt  = (q_step == seed_ref);
      end
`else
      q_nxt     = q_step;
      count_nxt = count + ONE;
      wrap_nxt  = (q_step == seed_ref);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      seed_ref <= '0;
      count    <= '0;
      wrap     <= 1'b0;
    end else begin
      q        <= q_nxt;
      seed_ref <= ref_nxt;
      count    <= count_nxt;
      wrap     <= wrap_nxt;
    end
  end

`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) recovered <= 1'b0;
    else      recovered <= rec_nxt;
  end
`else
  assign recovered = 1'b0;
`endif

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal range 3..32.
REQ-002 Parameter TAPS, default 8'hB8, feedback tap mask (bit i set = q[i] tapped); bit WIDTH-1 SHALL be set; tap count SHALL be even.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  advance one step this cycle.
REQ-006 load  input  1  load seed this cycle; overrides en.
REQ-007 seed  input  WIDTH  value loaded on load.
REQ-008 q  output  WIDTH  current LFSR state (registered).
REQ-009 bit_out  output  1  serial output, combinational q[WIDTH-1].
REQ-010 count  output  WIDTH  steps since last load/reset/recovery, registered, wraps mod 2^WIDTH.
REQ-011 wrap  output  1  registered one-cycle pulse: state returned to reference value.
REQ-012 lockup  output  1  combinational, high when q is all ones.
REQ-013 recovered  output  1  registered one-cycle pulse on lockup recovery (tied 0 when REQ-023 feature absent).

Function
REQ-014 Feedback SHALL be fb = XNOR-reduction of (q AND TAPS); step SHALL be q <= {q[WIDTH-2:0], fb}.
REQ-015 Internal reference register ref SHALL hold the last loaded seed (0 after reset).
REQ-016 load=1: q <= seed, ref <= seed, count <= 0, wrap <= 0, regardless of en.
REQ-017 en=1, load=0: q steps per REQ-014, count <= count+1 (mod 2^WIDTH), wrap <= 1 iff stepped next state equals ref, else 0.
REQ-018 en=0, load=0: q, count, ref hold; wrap and recovered <= 0.
REQ-019 Latency: new q, count, wrap visible the cycle after the qualifying edge; no pipeline stages.
REQ-020 All-ones is the XNOR lock-up state; with even tap count it maps to itself.
REQ-021 Default WIDTH/TAPS SHALL give maximal period 255 from any non-lock-up seed.

Reset
REQ-022 rst low SHALL asynchronously force q=0, ref=0, count=0, wrap=0, recovered=0; release takes effect at the first rising clk edge with rst high; assertion mid-sequence discards all state.

Configuration
REQ-023 Macro LFSR_GEN_LOCKUP_RECOVER_EN: when defined, en=1, load=0 with q all ones SHALL instead set q <= 0, ref <= 0, count <= 0, wrap <= 0, recovered <= 1; when undefined, recovery logic is absent, the lock-up state steps per REQ-017 (q stays all ones, count increments, wrap pulses each step since next equals ref when ref is all ones), and recovered is constant 0.

Verification
REQ-024 Reset, en=1 for 5 cycles -> q = 01, 03, 07, 0F, 1E; count = 1..5; wrap=0; bit_out=0.
REQ-025 Reset, en=1 for 255 cycles -> after 255th step q=00, count=255 (8'hFF), wrap high exactly that one cycle; all 255 states distinct.
REQ-026 load=1 with seed=8'h5A and en=1 same cycle -> q=5A, count=0, no step; then 255 en cycles -> wrap pulse with q=5A.
REQ-027 en toggled 1/0 each cycle from reset -> q advances only on en cycles; count equals number of en cycles; wrap/recovered low on idle cycles.
REQ-028 load seed=8'hFF -> lockup=1; next en: with LFSR_GEN_LOCKUP_RECOVER_EN q=00, count=0, recovered one-cycle pulse, lockup=0; without it q=FF, count=1, wrap=1, recovered=0.
REQ-029 rst asserted mid-sequence (q=1E) between edges -> q, count, wrap, recovered zero immediately without clock; sequence restarts at 01 on first en after release.
